vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
Controller for the chocolate vending machine. It accepts debounced single-cycle coin pulses and accumulates credit. When credit reaches PRICE it sequences the dispense actuator, then pays change one coin at a time. If the customer stops inserting coins, it refunds the credit after a timeout. It sits between the button debouncers and the LED/actuator outputs, and it runs in the divided clock domain.

Parameters:
PRICE, 25, product price in currency units; must be a multiple of 5 and no greater than 2^CREDIT_W-21.
CREDIT_W, 7, width of the credit and remaining-change registers.
DISP_CYCLES, 4, number of cycles the dispense output is held high; must be at least 1.
CHG_GAP, 2, number of low cycles between consecutive change pulses.
TIMEOUT, 1000, number of idle cycles in COLLECT before a refund; must be at least 2.

Ports:
clk  in  1  single clock, rising-edge.
rst  in  1  synchronous reset, active-high.
c5  in  1  one-cycle pulse: 5-unit coin inserted.
c10  in  1  one-cycle pulse: 10-unit coin inserted.
c20  in  1  one-cycle pulse: 20-unit coin inserted.
dispense  out  1  product actuator, high for DISP_CYCLES cycles.
chg5  out  1  one-cycle pulse: eject one 5-unit coin.
chg10  out  1  one-cycle pulse: eject one 10-unit coin.
coin_reject  out  1  one-cycle pulse: the inserted coin is returned and not credited.
busy  out  1  high in DISPENSE and CHANGE.
credit  out  CREDIT_W  current accepted credit.
led  out  4  status: {dispense, in CHANGE, refund in progress, credit!=0}.

Behaviour:
- One clock; reset is synchronous and active-high; ports are named clk and rst. All outputs are registered.
- Reset (any state, including mid-dispense or mid-change): next cycle state=IDLE, credit=0, remaining=0, all counters=0, all outputs=0.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Coin selection: if several coin inputs are high in one cycle, only the highest value is accepted (priority 20>10>5). coin_reject pulses on the next cycle.
- IDLE/COLLECT, coin accepted at edge N: credit is updated at edge N, so it is visible in cycle N+1. The timeout counter clears.
  - If credit+coin >= PRICE: go to DISPENSE; remaining = credit+coin-PRICE; credit = 0; dispense is high from cycle N+1.
  - Otherwise: go to COLLECT with the new credit.
- COLLECT, no coin: the timeout counter increments.
  - When it reaches TIMEOUT-1: go to CHANGE with remaining=credit, credit=0, and the refund flag set (led[1]=1).
- DISPENSE: dispense is high for exactly DISP_CYCLES cycles. Afterwards, go to CHANGE if remaining!=0, else IDLE.
- CHANGE: the first pulse is emitted on the first cycle in CHANGE. Selection is greedy:
  - chg10 if remaining>=10, else chg5; remaining decrements by 10 or 5.
  - After each pulse there are CHG_GAP low cycles before the next pulse.
  - After the pulse that brings remaining to 0, the next state is IDLE with no trailing gap. The refund flag clears on exit.
- Coins arriving in DISPENSE or CHANGE are not credited: coin_reject pulses the next cycle and state is unaffected.
- credit never exceeds PRICE+15, so it cannot overflow.
- busy=1 exactly while in DISPENSE or CHANGE. dispense, chg5 and chg10 are never high in the same cycle.

Test Plan:
1. Default parameters. c20, then c10 5 cycles later → credit=20 after the first coin; dispense high for 4 cycles starting the cycle after c10; then one chg5 pulse; IDLE; credit=0.
2. c5 ×5, in separate cycles → credit steps 5,10,15,20; 5th coin → dispense ×4 cycles, no change pulses, back to IDLE.
3. c20, c20 → remaining=15 → dispense ×4, then chg10, two low cycles, chg5, then IDLE. Total chg value = 15.
4. c10 then no coins → exactly TIMEOUT cycles later, refund: led[1]=1 and one chg10 pulse; dispense never rises; credit=0.
5. c5 and c20 high in the same cycle → credit=20 and coin_reject pulses once. c10 during DISPENSE → coin_reject pulses, remaining unchanged.
6. Assert rst in the cycle between chg10 and chg5 of scenario 3 → next cycle all outputs=0 and state=IDLE; no further chg pulses; a new c20 is accepted normally.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending-machine sequencer: accumulates coin credit, drives the dispense
// actuator, then pays change (or a timeout refund) one coin at a time.
module vend_sequencer #(
  parameter int PRICE       = 25,
  parameter int CREDIT_W    = 7,
  parameter int DISP_CYCLES = 4,
  parameter int CHG_GAP     = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c5,
  input  logic                c10,
  input  logic                c20,
  output logic                dispense,
  output logic                chg5,
  output logic                chg10,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          led
);

  localparam int TMO_W   = $clog2(TIMEOUT);
  localparam int CNT_MAX = (DISP_CYCLES > CHG_GAP) ? DISP_CYCLES : CHG_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit;
  logic [CREDIT_W-1:0] r_rem, w_rem;
  logic [TMO_W-1:0]    r_tmo, w_tmo;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_refund, w_refund;
  logic                r_dispense, r_chg5, r_chg10, r_reject, r_busy;
  logic [3:0]          r_led;

  logic                w_chg5, w_chg10, w_reject;
  logic                w_fire;
  logic [CREDIT_W-1:0] w_fire_src;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_coin_any, w_multi;

  // Coin priority decode: highest-value coin wins, the rest are returned.
  always_comb begin
    w_coin_any = c5 | c10 | c20;
    w_multi    = (c5 & c10) | (c5 & c20) | (c10 & c20);
    if (c20) begin
      w_coin_val = CREDIT_W'(20);
    end else if (c10) begin
      w_coin_val = CREDIT_W'(10);
    end else if (c5) begin
      w_coin_val = CREDIT_W'(5);
    end else begin
      w_coin_val = '0;
    end
    w_sum = r_credit + w_coin_val;
  end

  // Next-state and next-value logic for the FSM and its datapath.
  always_comb begin
    w_state    = r_state;
    w_credit   = r_credit;
    w_rem      = r_rem;
    w_tmo      = r_tmo;
    w_cnt      = r_cnt;
    w_refund   = r_refund;
    w_chg5     = 1'b0;
    w_chg10    = 1'b0;
    w_reject   = 1'b0;
    w_fire     = 1'b0;
    w_fire_src = r_rem;

    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_coin_any) begin
          w_reject = w_multi;
          w_tmo    = '0;
          if (w_sum >= CREDIT_W'(PRICE)) begin
            w_state  = S_DISPENSE;
            w_rem    = w_sum - CREDIT_W'(PRICE);
            w_credit = '0;
            w_cnt    = '0;
          end else begin
            w_state  = S_COLLECT;
            w_credit = w_sum;
          end
        end else if (r_state == S_COLLECT) begin
          if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            // Customer walked away: the whole credit goes back as change.
            w_state    = S_CHANGE;
            w_fire     = 1'b1;
            w_fire_src = r_credit;
            w_credit   = '0;
            w_refund   = 1'b1;
            w_tmo      = '0;
          end else begin
            w_tmo = r_tmo + TMO_W'(1);
          end
        end else begin
          w_tmo = '0;
        end
      end
      S_DISPENSE: begin
        w_reject = w_coin_any;
        if (r_cnt == CNT_W'(DISP_CYCLES - 1)) begin
          if (r_rem != '0) begin
            w_state    = S_CHANGE;
            w_fire     = 1'b1;
            w_fire_src = r_rem;
          end else begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_CHANGE: begin
        w_reject = w_coin_any;
        if (r_rem == '0) begin
          w_state  = S_IDLE;
          w_refund = 1'b0;
          w_cnt    = '0;
        end else if (r_cnt == CNT_W'(CHG_GAP)) begin
          w_fire     = 1'b1;
          w_fire_src = r_rem;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Greedy change: a pulse is issued in the same edge that enters CHANGE.
    if (w_fire) begin
      w_cnt = '0;
      if (w_fire_src >= CREDIT_W'(10)) begin
        w_chg10 = 1'b1;
        w_rem   = w_fire_src - CREDIT_W'(10);
      end else begin
        w_chg5 = 1'b1;
        w_rem  = w_fire_src - CREDIT_W'(5);
      end
    end else begin
      w_cnt = w_cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath registers and registered outputs, derived from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit   <= '0;
      r_rem      <= '0;
      r_tmo      <= '0;
      r_cnt      <= '0;
      r_refund   <= 1'b0;
      r_dispense <= 1'b0;
      r_chg5     <= 1'b0;
      r_chg10    <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
      r_led      <= 4'd0;
    end else begin
      r_credit   <= w_credit;
      r_rem      <= w_rem;
      r_tmo      <= w_tmo;
      r_cnt      <= w_cnt;
      r_refund   <= w_refund;
      r_dispense <= (w_state == S_DISPENSE);
      r_chg5     <= w_chg5;
      r_chg10    <= w_chg10;
      r_reject   <= w_reject;
      r_busy     <= (w_state == S_DISPENSE) || (w_state == S_CHANGE);
      r_led      <= {(w_state == S_DISPENSE), (w_state == S_CHANGE), w_refund,
                     (w_credit != '0)};
    end
  end

  assign dispense    = r_dispense;
  assign chg5        = r_chg5;
  assign chg10       = r_chg10;
  assign coin_reject = r_reject;
  assign busy        = r_busy;
  assign credit      = r_credit;
  assign led         = r_led;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer with default parameters.
module tb_vend_sequencer;

  logic       clk;
  logic       rst;
  logic       c5, c10, c20;
  logic       dispense, chg5, chg10, coin_reject, busy;
  logic [6:0] credit;
  logic [3:0] led;

  int n_checks;
  int n_errors;
  logic saw_disp;
  logic saw_chg;

  vend_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .c5          (c5),
    .c10         (c10),
    .c20         (c20),
    .dispense    (dispense),
    .chg5        (chg5),
    .chg10       (chg10),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic a5, input logic a10, input logic a20);
    c5  = a5;
    c10 = a10;
    c20 = a20;
    @(posedge clk);
    #1;
    c5  = 1'b0;
    c10 = 1'b0;
    c20 = 1'b0;
  endtask

  // Packed order: dispense, chg10, chg5, coin_reject, busy, led[3:0], credit[6:0]
  task automatic chk(input string tag, input logic e_d, input logic e_c10,
                     input logic e_c5, input logic e_rej, input logic e_busy,
                     input logic [3:0] e_led, input logic [6:0] e_cr);
    logic [15:0] obs;
    logic [15:0] expv;
    obs  = {dispense, chg10, chg5, coin_reject, busy, led, credit};
    expv = {e_d, e_c10, e_c5, e_rej, e_busy, e_led, e_cr};
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    c5 = 1'b0; c10 = 1'b0; c20 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 1: c20, then c10 -> dispense, one chg5
    coin(1'b0, 1'b0, 1'b1);
    chk("s1_credit20", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd20);
    for (int i = 0; i < 4; i++) tick();
    chk("s1_hold20", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd20);
    coin(1'b0, 1'b1, 1'b0);
    chk("s1_disp1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("s1_dispN", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    end
    tick();
    chk("s1_chg5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 2: five c5 coins, exact price, no change
    coin(1'b1, 1'b0, 1'b0);
    chk("s2_c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd5);
    coin(1'b1, 1'b0, 1'b0);
    chk("s2_c10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd10);
    coin(1'b1, 1'b0, 1'b0);
    chk("s2_c15", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd15);
    coin(1'b1, 1'b0, 1'b0);
    chk("s2_c20", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd20);
    coin(1'b1, 1'b0, 1'b0);
    chk("s2_disp1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("s2_dispN", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    end
    tick();
    chk("s2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);
    tick();
    chk("s2_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 3: c20, c20 -> remaining 15 -> chg10, gap x2, chg5
    coin(1'b0, 1'b0, 1'b1);
    coin(1'b0, 1'b0, 1'b1);
    chk("s3_disp1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("s3_disp4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    tick();
    chk("s3_chg10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s3_gap1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s3_gap2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s3_chg5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 5: simultaneous coins, then a coin during dispense
    coin(1'b1, 1'b0, 1'b1);
    chk("s5_multi", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 7'd20);
    tick();
    chk("s5_rej_once", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd20);
    coin(1'b0, 1'b1, 1'b0);
    chk("s5_disp1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    coin(1'b0, 1'b1, 1'b0);
    chk("s5_disp_rej", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 7'd0);
    tick();
    chk("s5_disp3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    tick();
    chk("s5_disp4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 7'd0);
    tick();
    chk("s5_chg5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 6: reset in the gap between chg10 and chg5
    coin(1'b0, 1'b0, 1'b1);
    coin(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("s6_chg10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 7'd0);
    tick();
    chk("s6_gap1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 7'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s6_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);
    end
    coin(1'b0, 1'b0, 1'b1);
    chk("s6_new_c20", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    // Scenario 4: c10 then idle -> refund after 1000 idle COLLECT cycles
    coin(1'b0, 1'b1, 1'b0);
    chk("s4_credit10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd10);
    saw_disp = 1'b0;
    saw_chg  = 1'b0;
    for (int i = 0; i < 999; i++) begin
      tick();
      saw_disp = saw_disp | dispense;
      saw_chg  = saw_chg | chg5 | chg10;
    end
    chk("s4_last_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 7'd10);
    n_checks++;
    assert ({saw_disp, saw_chg} === 2'b00) else begin
      n_errors++;
      $error("FAIL s4_early_activity: observed %b expected %b", {saw_disp, saw_chg}, 2'b00);
    end
    tick();
    chk("s4_refund", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 7'd0);
    tick();
    chk("s4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
